// File: rtl/ram_arb_pkg.sv
// Shared owner encoding and response timing for the RAM port-A arbiter.
// Imported by ram_arb_grant and ram_port_arbiter.
package ram_arb_pkg;

    typedef logic owner_t;

    localparam owner_t OWNER_R0    = 1'b0;
    localparam owner_t OWNER_R1    = 1'b1;
    localparam int     RSP_LATENCY = 1;

endpackage

// File: rtl/ram_arb_grant.sv
// Combinational grant decision: lock continuation with forced handover, else contention resolved by pref_i.
// Latency 0; a requester that is not granted simply sees no ready and must hold its request.
module ram_arb_grant
    import ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic [1:0]       valid_i,
    input  logic             lock_q_i,
    input  owner_t           owner_q_i,
    input  logic [CNT_W-1:0] hold_cnt_q_i,
    input  owner_t           pref_i,
    output logic             gnt_vld_o,
    output owner_t           gnt_owner_o,
    output logic             gnt_locked_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    owner_t other;

    always_comb begin
        gnt_vld_o    = |valid_i;
        gnt_owner_o  = OWNER_R0;
        gnt_locked_o = 1'b0;
        other        = owner_t'(~owner_q_i);
        if (lock_q_i && valid_i[owner_q_i]) begin
            // Burst owner keeps the port until it has used its full hold allowance.
            if ((hold_cnt_q_i == HOLD_LAST) && valid_i[other]) begin
                gnt_owner_o = other;
            end else begin
                gnt_owner_o  = owner_q_i;
                gnt_locked_o = 1'b1;
            end
        end else if (valid_i == 2'b11) begin
            gnt_owner_o = pref_i;
        end else if (valid_i[1]) begin
            gnt_owner_o = OWNER_R1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between R0 (CPU) and R1 (DMA); one access/cycle, response 1 cycle after transfer.
// Build option RAM_ARB_RR_EN selects round-robin instead of fixed R1 priority on contention.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  DEPTH    = 16384,
    parameter int  MAX_HOLD = 8,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_lock,
    input  logic [3:0]        r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_rsp_valid,
    output logic [31:0]       r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_lock,
    input  logic [3:0]        r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_rsp_valid,
    output logic [31:0]       r1_rdata,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_q
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    owner_t            owner_q, owner_d, rsp_owner_q, rsp_owner_d, gnt_owner, pref_owner;
    logic              lock_q, lock_d, rsp_vld_q, rsp_vld_d;
    logic              gnt_raw, gnt, gnt_locked, sel_lock, rsp0, rsp1;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
    logic [31:0]       wdata_q, wdata_d, sel_wdata;
    logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [3:0]        sel_we;

`ifdef RAM_ARB_RR_EN
    owner_t last_q, last_d;

    assign last_d     = gnt ? gnt_owner : last_q;
    assign pref_owner = owner_t'(~last_q);

    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= OWNER_R1;
        else        last_q <= last_d;
    end
`else
    assign pref_owner = OWNER_R1;
`endif

    ram_arb_grant #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_grant (
        .valid_i      ({r1_valid, r0_valid}),
        .lock_q_i     (lock_q),
        .owner_q_i    (owner_q),
        .hold_cnt_q_i (hold_cnt_q),
        .pref_i       (pref_owner),
        .gnt_vld_o    (gnt_raw),
        .gnt_owner_o  (gnt_owner),
        .gnt_locked_o (gnt_locked)
    );

    // Outputs are forced to their reset values for as long as rst_n is low.
    assign gnt       = gnt_raw & rst_n;
    assign sel_we    = (gnt_owner == OWNER_R1) ? r1_we    : r0_we;
    assign sel_addr  = (gnt_owner == OWNER_R1) ? r1_addr  : r0_addr;
    assign sel_wdata = (gnt_owner == OWNER_R1) ? r1_wdata : r0_wdata;
    assign sel_lock  = (gnt_owner == OWNER_R1) ? r1_lock  : r0_lock;

    assign r0_ready  = gnt & (gnt_owner == OWNER_R0);
    assign r1_ready  = gnt & (gnt_owner == OWNER_R1);
    assign ram_we    = gnt ? sel_we : 4'b0000;
    assign ram_addr  = !rst_n ? '0 : (gnt ? sel_addr : addr_q);
    assign ram_wdata = !rst_n ? '0 : (gnt ? sel_wdata : wdata_q);

    assign rsp0         = rst_n & rsp_vld_q & (rsp_owner_q == OWNER_R0);
    assign rsp1         = rst_n & rsp_vld_q & (rsp_owner_q == OWNER_R1);
    assign r0_rsp_valid = rsp0;
    assign r1_rsp_valid = rsp1;
    assign r0_rdata     = !rst_n ? '0 : (rsp0 ? ram_q : rdata0_q);
    assign r1_rdata     = !rst_n ? '0 : (rsp1 ? ram_q : rdata1_q);

    always_comb begin
        owner_d     = owner_q;
        rsp_owner_d = rsp_owner_q;
        rsp_vld_d   = gnt;
        lock_d      = 1'b0;
        hold_cnt_d  = '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = r0_rdata;
        rdata1_d    = r1_rdata;
        if (gnt) begin
            owner_d     = gnt_owner;
            rsp_owner_d = gnt_owner;
            lock_d      = sel_lock;
            addr_d      = sel_addr;
            wdata_d     = sel_wdata;
            // Saturates so a lone locked owner can keep bursting without wrapping.
            if (gnt_locked) begin
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= OWNER_R0;
            rsp_owner_q <= OWNER_R0;
            rsp_vld_q   <= 1'b0;
            lock_q      <= 1'b0;
            hold_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_vld_q   <= rsp_vld_d;
            lock_q      <= lock_d;
            hold_cnt_q  <= hold_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

endmodule
